// File: rtl/temp_meas_pkg.sv
// rtl/temp_meas_pkg.sv - shared types and helpers for the temperature measurement sequencer
package temp_meas_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    SETTLE,
    ACCUM,
    HOLD
  } state_t;

  localparam int MAX_AVG_LOG2 = 3;

  // Clk cycles spent on one window: CLEAR + RUN + SETTLE + ACCUM.
  function automatic int unsigned window_cycles(input int unsigned win, input int unsigned settle);
    return ((win == 0) ? 1 : win) + settle + 2;
  endfunction

endpackage

// File: rtl/temp_meas_ctrl_if.sv
// rtl/temp_meas_ctrl_if.sv - result valid/ready interface of the measurement sequencer
interface temp_meas_ctrl_if #(
  parameter int ACC_WIDTH = 11
);
  logic [ACC_WIDTH-1:0] result;
  logic                 result_valid;
  logic                 result_ready;

  modport master (output result, output result_valid, input result_ready);
  modport slave  (input result, input result_valid, output result_ready);
endinterface

// File: rtl/temp_meas_timer.sv
// rtl/temp_meas_timer.sv - loadable down-counter timing the RUN and SETTLE phases
module temp_meas_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  output logic             done
);

  logic [WIDTH-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/temp_meas_ctrl.sv
// rtl/temp_meas_ctrl.sv - gates the temperature oscillator per window and sums 1/2/4/8 counts
module temp_meas_ctrl
  import temp_meas_pkg::*;
#(
  parameter int CNT_WIDTH     = 8,
  parameter int WIN_WIDTH     = 16,
  parameter int SETTLE_CYCLES = 4,
  parameter int ACC_WIDTH     = 11
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 continuous,
  input  logic [WIN_WIDTH-1:0] win_len,
  input  logic [1:0]           avg_log2,
  input  logic [CNT_WIDTH-1:0] count,
  output logic                 osc_en,
  output logic                 cnt_reset,
  output logic                 busy,
  output logic                 overrun,
  temp_meas_ctrl_if.master     res
);

  localparam int IDX_W = MAX_AVG_LOG2 + 1;

  if (ACC_WIDTH < CNT_WIDTH + 3) begin : g_acc_width_check
    $error("temp_meas_ctrl: ACC_WIDTH must be >= CNT_WIDTH+3");
  end
  if (SETTLE_CYCLES < 1) begin : g_settle_check
    $error("temp_meas_ctrl: SETTLE_CYCLES must be >= 1");
  end

  state_t               state, state_next;
  logic [WIN_WIDTH-1:0] win_q;
  logic [1:0]           avg_q;
  logic [IDX_W-1:0]     widx;
  logic [ACC_WIDTH-1:0] acc, acc_sum;
  logic                 arm, last_win, handshake;
  logic                 tmr_load, tmr_en, tmr_done;
  logic [WIN_WIDTH-1:0] tmr_val;

  assign handshake = (state == HOLD) && res.result_ready;
  assign acc_sum   = acc + ACC_WIDTH'(count);
  assign last_win  = ((widx + 1'b1) == (IDX_W'(1) << avg_q));

  temp_meas_timer #(.WIDTH(WIN_WIDTH)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .done     (tmr_done)
  );

  always_comb begin
    state_next = state;
    arm        = 1'b0;
    tmr_load   = 1'b0;
    tmr_en     = 1'b0;
    tmr_val    = win_q - 1'b1;
    case (state)
      IDLE: begin
        if (start || continuous) begin
          state_next = CLEAR;
          arm        = 1'b1;
        end
      end
      CLEAR: begin
        state_next = RUN;
        tmr_load   = 1'b1;
      end
      RUN: begin
        if (tmr_done) begin
          state_next = SETTLE;
          tmr_load   = 1'b1;
          tmr_val    = WIN_WIDTH'(SETTLE_CYCLES - 1);
        end else begin
          tmr_en = 1'b1;
        end
      end
      SETTLE: begin
        if (tmr_done) state_next = ACCUM;
        else          tmr_en     = 1'b1;
      end
      ACCUM: state_next = last_win ? HOLD : CLEAR;
      HOLD: begin
        if (handshake) begin
          if (continuous) begin
            state_next = CLEAR;
            arm        = 1'b1;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are flops decoded from the next state so they track the state register glitch-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      win_q            <= WIN_WIDTH'(1);
      avg_q            <= '0;
      widx             <= '0;
      acc              <= '0;
      res.result       <= '0;
      res.result_valid <= 1'b0;
      osc_en           <= 1'b0;
      cnt_reset        <= 1'b1;
      busy             <= 1'b0;
      overrun          <= 1'b0;
    end else begin
      state            <= state_next;
      osc_en           <= (state_next == RUN);
      cnt_reset        <= (state_next == IDLE) || (state_next == CLEAR) || (state_next == HOLD);
      res.result_valid <= (state_next == HOLD);
      busy             <= (state_next != IDLE);
      if (arm) begin
        win_q <= (win_len == '0) ? WIN_WIDTH'(1) : win_len;
        avg_q <= avg_log2;
        widx  <= '0;
        acc   <= '0;
      end else if (state == ACCUM) begin
        acc  <= acc_sum;
        widx <= widx + 1'b1;
        if (last_win) res.result <= acc_sum;
      end
      if (handshake) begin
        overrun <= 1'b0;
      end else if (start && (state != IDLE)) begin
        overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_temp_meas_ctrl.sv
// tb/tb_temp_meas_ctrl.sv - vector-table and sequence bench for temp_meas_ctrl
module tb_temp_meas_ctrl;

  logic        clk;
  logic        reset;
  logic        start;
  logic        continuous;
  logic [15:0] win_len;
  logic [1:0]  avg_log2;
  logic [7:0]  count;
  logic        osc_en;
  logic        cnt_reset;
  logic        busy;
  logic        overrun;

  int checks   = 0;
  int failures = 0;
  int overlap  = 0;

  temp_meas_ctrl_if #(.ACC_WIDTH(11)) res_if ();

  temp_meas_ctrl #(
    .CNT_WIDTH     (8),
    .WIN_WIDTH     (16),
    .SETTLE_CYCLES (4),
    .ACC_WIDTH     (11)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .continuous (continuous),
    .win_len    (win_len),
    .avg_log2   (avg_log2),
    .count      (count),
    .osc_en     (osc_en),
    .cnt_reset  (cnt_reset),
    .busy       (busy),
    .overrun    (overrun),
    .res        (res_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Oscillator ripple counter model: counts one per clk while gated, clears while held in reset.
  always @(posedge clk) begin
    if (cnt_reset)   count <= '0;
    else if (osc_en) count <= count + 8'd1;
  end

  typedef struct {
    int w;
    int a;
    int exp_res;
    int exp_lat;
    int exp_osc;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic start_meas(input int w, input int a);
    @(negedge clk);
    win_len  = 16'(w);
    avg_log2 = 2'(a);
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_valid(output int lat, output int osc_cyc, output int rises);
    logic prev;
    lat     = 0;
    osc_cyc = 0;
    rises   = 0;
    prev    = cnt_reset;
    while (!res_if.result_valid && lat < 5000) begin
      @(negedge clk);
      lat++;
      if (osc_en) osc_cyc++;
      if (cnt_reset && !prev) rises++;
      if (osc_en && cnt_reset) overlap++;
      prev = cnt_reset;
    end
    chk("valid_seen", int'(res_if.result_valid), 1);
  endtask

  task automatic accept();
    @(negedge clk);
    res_if.result_ready = 1'b1;
    @(negedge clk);
    res_if.result_ready = 1'b0;
  endtask

  initial begin
    int lat, oc, rr, stable;
    vecs[0] = '{100, 0, 100,  106,  100};
    vecs[1] = '{ 50, 2, 200,  224,  200};
    vecs[2] = '{  0, 0,   1,    7,    1};
    vecs[3] = '{  7, 1,  14,   26,   14};
    vecs[4] = '{255, 3, 2040, 2088, 2040};
    vecs[5] = '{  1, 3,   8,   56,    8};

    reset               = 1'b1;
    start               = 1'b0;
    continuous          = 1'b0;
    win_len             = 16'd0;
    avg_log2            = 2'd0;
    res_if.result_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_osc_en", int'(osc_en), 0);
    chk("rst_cnt_reset", int'(cnt_reset), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_result", int'(res_if.result), 0);
    chk("rst_valid", int'(res_if.result_valid), 0);
    chk("rst_overrun", int'(overrun), 0);
    reset = 1'b0;

    for (int i = 0; i < 6; i++) begin
      start_meas(vecs[i].w, vecs[i].a);
      wait_valid(lat, oc, rr);
      chk($sformatf("v%0d_result", i), int'(res_if.result), vecs[i].exp_res);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      chk($sformatf("v%0d_osc_cycles", i), oc, vecs[i].exp_osc);
      chk($sformatf("v%0d_cnt_reset_pulses", i), rr, 1 << vecs[i].a);
      chk($sformatf("v%0d_busy_hold", i), int'(busy), 1);
      accept();
      chk($sformatf("v%0d_valid_drop", i), int'(res_if.result_valid), 0);
      chk($sformatf("v%0d_idle_busy", i), int'(busy), 0);
    end

    // Backpressure: result must stay parked for 10 cycles with the oscillator off.
    start_meas(100, 0);
    wait_valid(lat, oc, rr);
    stable = 1;
    repeat (10) begin
      @(negedge clk);
      if (res_if.result !== 11'd100 || res_if.result_valid !== 1'b1 || osc_en !== 1'b0 || cnt_reset !== 1'b1)
        stable = 0;
    end
    chk("bp_stable", stable, 1);
    accept();
    chk("bp_valid_drop", int'(res_if.result_valid), 0);

    // Continuous mode: re-arm right after each handshake; win_len change lands one measurement later.
    @(negedge clk);
    win_len    = 16'd20;
    avg_log2   = 2'd0;
    continuous = 1'b1;
    @(negedge clk);
    wait_valid(lat, oc, rr);
    chk("cont_a_result", int'(res_if.result), 20);
    chk("cont_a_latency", lat, 26);
    accept();
    chk("cont_clear_valid", int'(res_if.result_valid), 0);
    chk("cont_clear_state", int'({osc_en, cnt_reset, busy}), 3);
    @(negedge clk);
    chk("cont_run_osc", int'(osc_en), 1);
    win_len = 16'd30;
    wait_valid(lat, oc, rr);
    chk("cont_b_result", int'(res_if.result), 20);
    chk("cont_b_latency", lat + 1, 26);
    accept();
    continuous = 1'b0;
    wait_valid(lat, oc, rr);
    chk("cont_c_result", int'(res_if.result), 30);
    chk("cont_c_latency", lat, 36);
    accept();
    chk("cont_end_busy", int'(busy), 0);

    // Start while busy raises overrun without disturbing the measurement.
    start_meas(100, 0);
    repeat (20) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ovr_set", int'(overrun), 1);
    wait_valid(lat, oc, rr);
    chk("ovr_latency", lat + 21, 106);
    chk("ovr_result", int'(res_if.result), 100);
    chk("ovr_held", int'(overrun), 1);
    accept();
    chk("ovr_cleared", int'(overrun), 0);

    // Start coinciding with the handshake: handshake wins, no overrun, no new measurement.
    start_meas(0, 0);
    wait_valid(lat, oc, rr);
    chk("sim_result", int'(res_if.result), 1);
    @(negedge clk);
    start               = 1'b1;
    res_if.result_ready = 1'b1;
    @(negedge clk);
    start               = 1'b0;
    res_if.result_ready = 1'b0;
    chk("sim_overrun", int'(overrun), 0);
    chk("sim_valid", int'(res_if.result_valid), 0);
    @(negedge clk);
    chk("sim_busy", int'(busy), 0);

    // Asynchronous reset in the middle of RUN.
    start_meas(100, 0);
    repeat (37) @(posedge clk);
    #1;
    chk("mid_pre_osc", int'(osc_en), 1);
    #1 reset = 1'b1;
    #1;
    chk("mid_osc_en", int'(osc_en), 0);
    chk("mid_cnt_reset", int'(cnt_reset), 1);
    chk("mid_busy", int'(busy), 0);
    chk("mid_result", int'(res_if.result), 0);
    @(negedge clk);
    reset = 1'b0;
    start_meas(100, 0);
    wait_valid(lat, oc, rr);
    chk("post_rst_result", int'(res_if.result), 100);
    chk("post_rst_latency", lat, 106);
    accept();

    chk("osc_cnt_overlap", overlap, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
